// File: rtl/l1_refill_arbiter.sv
// l1_refill_arbiter: shared I/D cache line refill and dirty-victim writeback
// controller driving one word-wide memory port.
//
// Ports
//   clk, rst                 core clock; asynchronous active-low reset
//   i_req, i_addr            I-cache line miss (held until i_done)
//   i_rdata/i_rvalid/i_widx  refill word stream to the I-cache
//   i_done                   one-cycle completion pulse for I
//   d_req, d_addr            D-cache line miss (held until d_done)
//   d_wb, d_wb_addr          dirty victim flag and line address, sampled at grant
//   d_wdata                  victim word selected by d_widx (combinational)
//   d_rdata/d_rvalid/d_widx  refill word stream / word index to the D-cache
//   d_done                   one-cycle completion pulse for D
//   mem_req/mem_we/mem_addr/mem_wdata/mem_ack/mem_rdata  memory word port
//   busy                     controller is not idle
//   gnt_d                    current owner is the D-cache

module l1_refill_arbiter #(
    parameter  int LINE_WORDS = 4,
    localparam int IDX_W      = $clog2(LINE_WORDS)
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             i_req,
    input  logic [31:0]      i_addr,
    output logic [31:0]      i_rdata,
    output logic             i_rvalid,
    output logic [IDX_W-1:0] i_widx,
    output logic             i_done,

    input  logic             d_req,
    input  logic [31:0]      d_addr,
    input  logic             d_wb,
    input  logic [31:0]      d_wb_addr,
    input  logic [31:0]      d_wdata,
    output logic [31:0]      d_rdata,
    output logic             d_rvalid,
    output logic [IDX_W-1:0] d_widx,
    output logic             d_done,

    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic             mem_ack,
    input  logic [31:0]      mem_rdata,

    output logic             busy,
    output logic             gnt_d
);

    localparam logic [31:0]      LINE_MASK = ~(32'(LINE_WORDS * 4) - 32'd1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        RD   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q,  last_d;
    logic [IDX_W-1:0] cnt_q,   cnt_d;
    logic [31:0]      base_q,  base_d;
    logic [31:0]      dline_q, dline_d;

    logic             pick_d;
    logic             last_word;
    logic [31:0]      word_addr;

    // Byte offset of the current word inside the line; never carries out
    // of the line because base is line-aligned.
    assign word_addr = base_q + {{(30-IDX_W){1'b0}}, cnt_q, 2'b00};
    assign last_word = (cnt_q == LAST_IDX);

    // Round-robin on a tie: the side that did not win last time goes first.
    assign pick_d = d_req & (~i_req | ~last_q);

    assign busy  = (state_q != IDLE);
    assign gnt_d = owner_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
            base_q  <= '0;
            dline_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            dline_q <= dline_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        base_d    = base_q;
        dline_d   = dline_q;

        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        i_rdata   = '0;
        i_rvalid  = 1'b0;
        i_widx    = '0;
        i_done    = 1'b0;
        d_rdata   = '0;
        d_rvalid  = 1'b0;
        d_widx    = '0;
        d_done    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    owner_d = pick_d;
                    last_d  = pick_d;
                    cnt_d   = '0;
                    if (pick_d && d_wb) begin
                        state_d = WB;
                        base_d  = d_wb_addr & LINE_MASK;
                        // Miss line is needed again once the victim is out.
                        dline_d = d_addr & LINE_MASK;
                    end else begin
                        state_d = RD;
                        base_d  = (pick_d ? d_addr : i_addr) & LINE_MASK;
                    end
                end
            end

            WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = word_addr;
                mem_wdata = d_wdata;
                d_widx    = cnt_q;
                if (mem_ack) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last_word) begin
                        base_d  = dline_q;
                        state_d = RD;
                    end
                end
            end

            RD: begin
                mem_req  = 1'b1;
                mem_addr = word_addr;
                if (owner_q) begin
                    d_widx = cnt_q;
                end else begin
                    i_widx = cnt_q;
                end
                if (mem_ack) begin
                    if (owner_q) begin
                        d_rvalid = 1'b1;
                        d_rdata  = mem_rdata;
                    end else begin
                        i_rvalid = 1'b1;
                        i_rdata  = mem_rdata;
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (last_word) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                d_done  = owner_q;
                i_done  = ~owner_q;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_l1_refill_arbiter.sv
// Directed bench for l1_refill_arbiter: transaction-level model plus
// hand-computed literal expectations.

module tb_l1_refill_arbiter;

    localparam int LW = 4;
    localparam int IW = $clog2(LW);
    localparam logic [31:0] RD_KEY = 32'h5A5A_0000;
    localparam logic [31:0] WB_KEY = 32'hA500_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_req = 1'b0;
    logic [31:0]   i_addr = '0;
    logic [31:0]   i_rdata;
    logic          i_rvalid;
    logic [IW-1:0] i_widx;
    logic          i_done;
    logic          d_req = 1'b0;
    logic [31:0]   d_addr = '0;
    logic          d_wb = 1'b0;
    logic [31:0]   d_wb_addr = '0;
    logic [31:0]   d_wdata;
    logic [31:0]   d_rdata;
    logic          d_rvalid;
    logic [IW-1:0] d_widx;
    logic          d_done;
    logic          mem_req;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_ack = 1'b0;
    logic [31:0]   mem_rdata;
    logic          busy;
    logic          gnt_d;

    int checks = 0;
    int failures = 0;

    // Cache supplies the victim word for the index it is shown;
    // memory returns an address-derived pattern.
    assign d_wdata   = WB_KEY | 32'(d_widx);
    assign mem_rdata = mem_addr ^ RD_KEY;

    always #5 clk = ~clk;

    l1_refill_arbiter #(.LINE_WORDS(LW)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata),
        .i_rvalid(i_rvalid), .i_widx(i_widx), .i_done(i_done),
        .d_req(d_req), .d_addr(d_addr), .d_wb(d_wb),
        .d_wb_addr(d_wb_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
        .d_rvalid(d_rvalid), .d_widx(d_widx), .d_done(d_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .busy(busy), .gnt_d(gnt_d)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct {
        bit          we;
        logic [31:0] addr;
        int          idx;
    } op_t;

    op_t ops[$];
    bit  m_done = 0;
    bit  m_own  = 0;
    bit  m_last = 0;

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return a - (a % (LW * 4));
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                ops.delete();
                m_done = 0;
                m_own  = 0;
                m_last = 0;
            end else if (m_done) begin
                m_done = 0;
            end else if (ops.size() > 0) begin
                if (mem_ack) begin
                    void'(ops.pop_front());
                    if (ops.size() == 0) m_done = 1;
                end
            end else if (i_req || d_req) begin
                bit      win_d;
                op_t     o;
                logic [31:0] rl;
                if (i_req && d_req) win_d = !m_last;
                else                win_d = d_req;
                m_own  = win_d;
                m_last = win_d;
                if (win_d && d_wb) begin
                    for (int k = 0; k < LW; k++) begin
                        o.we = 1; o.addr = line_of(d_wb_addr) + 32'(4 * k); o.idx = k;
                        ops.push_back(o);
                    end
                end
                rl = line_of(win_d ? d_addr : i_addr);
                for (int k = 0; k < LW; k++) begin
                    o.we = 0; o.addr = rl + 32'(4 * k); o.idx = k;
                    ops.push_back(o);
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            begin
                bit  act_q;
                op_t h;
                bit  rd_ok;
                act_q = ops.size() > 0;
                if (act_q) h = ops[0];
                chk("busy", busy, act_q || m_done);
                chk("mem_req", mem_req, act_q);
                chk("i_done", i_done, m_done && !m_own);
                chk("d_done", d_done, m_done && m_own);
                if (act_q || m_done) chk("gnt_d", gnt_d, m_own);
                rd_ok = act_q && !h.we && mem_ack;
                chk("i_rvalid", i_rvalid, rd_ok && !m_own);
                chk("d_rvalid", d_rvalid, rd_ok && m_own);
                if (act_q) begin
                    chk("mem_we", mem_we, h.we);
                    chk("mem_addr", mem_addr, h.addr);
                    if (h.we) begin
                        chk("mem_wdata", mem_wdata, WB_KEY | 32'(h.idx));
                        chk("d_widx_wb", d_widx, h.idx);
                    end
                    if (rd_ok && !m_own) begin
                        chk("i_rdata", i_rdata, h.addr ^ RD_KEY);
                        chk("i_widx", i_widx, h.idx);
                    end
                    if (rd_ok && m_own) begin
                        chk("d_rdata", d_rdata, h.addr ^ RD_KEY);
                        chk("d_widx", d_widx, h.idx);
                    end
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input bit want_d);
        bit got = 0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            got = want_d ? d_done : i_done;
        end
        chk(want_d ? "wait_d_done" : "wait_i_done", got, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_gnt_d", gnt_d, 0);
        chk("rst_i_done", i_done, 0);
        chk("rst_d_rvalid", d_rvalid, 0);
        rst = 1'b1;

        // Tie right after reset: D wins, then I, then D again.
        cyc();
        i_req = 1; i_addr = 32'h0000_0400;
        d_req = 1; d_addr = 32'h0000_0500; d_wb = 0;
        mem_ack = 1;
        @(posedge clk);
        @(negedge clk);
        chk("tie1_gnt_d", gnt_d, 1);
        chk("tie1_addr", mem_addr, 32'h500);
        wait_done(1);
        cyc();
        d_req = 0;
        @(posedge clk);
        @(negedge clk);
        chk("tie1_i_busy", busy, 1);
        chk("tie1_i_gnt", gnt_d, 0);
        chk("tie1_i_addr", mem_addr, 32'h400);
        wait_done(0);
        cyc();
        i_req = 0;
        cyc();
        i_req = 1; d_req = 1;
        @(posedge clk);
        @(negedge clk);
        chk("tie2_gnt_d", gnt_d, 1);
        wait_done(1);
        cyc();
        d_req = 0;
        wait_done(0);
        cyc();
        i_req = 0;

        // I-only burst, ack always 1.
        cyc();
        i_req = 1; i_addr = 32'h0000_0108; mem_ack = 1;
        @(posedge clk);
        for (int k = 0; k < LW; k++) begin
            @(negedge clk);
            chk("t1_addr", mem_addr, 32'h100 + 32'(4 * k));
            chk("t1_rvalid", i_rvalid, 1);
            chk("t1_widx", i_widx, k);
        end
        @(negedge clk);
        chk("t1_done", i_done, 1);
        cyc();
        i_req = 0;
        @(negedge clk);
        chk("t1_busy_fall", busy, 0);

        // D miss with dirty victim.
        cyc();
        d_req = 1; d_wb = 1; d_wb_addr = 32'h2000; d_addr = 32'h3004;
        @(posedge clk);
        for (int k = 0; k < LW; k++) begin
            @(negedge clk);
            chk("t2_wb_we", mem_we, 1);
            chk("t2_wb_addr", mem_addr, 32'h2000 + 32'(4 * k));
            chk("t2_wb_data", mem_wdata, 32'hA500_0000 + 32'(k));
        end
        for (int k = 0; k < LW; k++) begin
            @(negedge clk);
            chk("t2_rd_we", mem_we, 0);
            chk("t2_rd_addr", mem_addr, 32'h3000 + 32'(4 * k));
            chk("t2_rd_valid", d_rvalid, 1);
        end
        @(negedge clk);
        chk("t2_done", d_done, 1);
        cyc();
        d_req = 0; d_wb = 0;

        // Stalled read: ack pattern 1,0,0,1,0,1,1.
        cyc();
        i_req = 1; i_addr = 32'h0000_0600; mem_ack = 0;
        begin
            logic [6:0]  pat;
            logic [31:0] exp_a [7];
            int          nv;
            pat = 7'b1101001;
            exp_a = '{32'h600, 32'h604, 32'h604, 32'h604,
                      32'h608, 32'h608, 32'h60C};
            nv = 0;
            @(posedge clk);
            #1 mem_ack = pat[0];
            for (int j = 0; j < 7; j++) begin
                @(negedge clk);
                chk("t4_addr", mem_addr, exp_a[j]);
                if (i_rvalid) nv++;
                @(posedge clk);
                #1 mem_ack = (j < 6) ? pat[j + 1] : 1'b1;
            end
            chk("t4_nvalid", nv, 4);
            @(negedge clk);
            chk("t4_done", i_done, 1);
        end
        cyc();
        i_req = 0;

        // Reset in the middle of a read burst.
        cyc();
        i_req = 1; i_addr = 32'h0000_0700; mem_ack = 1;
        repeat (3) @(posedge clk);
        #2;
        chk("t5_addr_w2", mem_addr, 32'h708);
        rst = 0;
        #1;
        chk("t5_req_drop", mem_req, 0);
        chk("t5_busy_drop", busy, 0);
        chk("t5_rvalid_drop", i_rvalid, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        @(negedge clk);
        chk("t5_restart_addr", mem_addr, 32'h700);
        chk("t5_restart_widx", i_widx, 0);
        wait_done(0);
        cyc();
        i_req = 0;

        // Requester drops mid-burst.
        cyc();
        i_req = 1; i_addr = 32'h0000_0800;
        @(posedge clk);
        @(posedge clk);
        #1 i_req = 0;
        begin
            int nd = 0;
            for (int n = 0; n < 12; n++) begin
                @(negedge clk);
                if (i_done) nd++;
            end
            chk("t6_done_count", nd, 1);
        end

        repeat (3) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
